// File: rtl/sampler_pkg.sv
// rtl/sampler_pkg.sv - shared default sizes for the input sampler
package sampler_pkg;
  localparam int SAMPLER_WIDTH = 32;
  localparam int SAMPLER_DIVW  = 24;
endpackage

// File: rtl/sample_divider.sv
// rtl/sample_divider.sv - sample-rate down-counter, one tick every divider+1 enabled clocks
module sample_divider import sampler_pkg::*; #(
  parameter int DIVW = SAMPLER_DIVW
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            enable,
  input  logic [DIVW-1:0] divider,
  output logic            tick
);

  logic [DIVW-1:0] count;

  assign tick = enable && (count == '0);

  // divider is only sampled on a reload, so a new value never truncates a running count
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      count <= divider;
    end else if (!enable || (count == '0)) begin
      count <= divider;
    end else begin
      count <= count - DIVW'(1);
    end
  end

endmodule

// File: rtl/input_sampler.sv
// rtl/input_sampler.sv - periodic sampler with one-deep output slot and sticky overrun
// Optional per-channel edge flags: INPUT_SAMPLER_EDGE_EN
module input_sampler import sampler_pkg::*; #(
  parameter int WIDTH = SAMPLER_WIDTH,
  parameter int DIVW  = SAMPLER_DIVW
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] sync_data,
  input  logic [DIVW-1:0]  divider,
  input  logic             enable,
  input  logic             clear_overrun,
  input  logic             sample_ready,
  output logic             sample_valid,
  output logic [WIDTH-1:0] sample_data,
  output logic             overrun
`ifdef INPUT_SAMPLER_EDGE_EN
  ,
  output logic [WIDTH-1:0] sample_rise,
  output logic [WIDTH-1:0] sample_fall
`endif
);

  logic tick;
  logic slot_free;
  logic capture;
  logic drop;

  sample_divider #(.DIVW(DIVW)) u_divider (
    .clk     (clk),
    .reset_n (reset_n),
    .enable  (enable),
    .divider (divider),
    .tick    (tick)
  );

  // an acceptance in the same cycle frees the slot, giving back-to-back samples
  assign slot_free = !sample_valid || sample_ready;
  assign capture   = tick && slot_free;
  assign drop      = tick && !slot_free;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sample_valid <= 1'b0;
      sample_data  <= '0;
      overrun      <= 1'b0;
    end else begin
      if (capture) begin
        sample_valid <= 1'b1;
        sample_data  <= sync_data;
      end else if (sample_ready) begin
        sample_valid <= 1'b0;
      end
      if (drop) begin
        overrun <= 1'b1;
      end else if (clear_overrun) begin
        overrun <= 1'b0;
      end
    end
  end

`ifdef INPUT_SAMPLER_EDGE_EN
  logic [WIDTH-1:0] prev;
  logic             prev_valid;

  // history is invalidated while disabled so the first capture reports no edges
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      prev        <= '0;
      prev_valid  <= 1'b0;
      sample_rise <= '0;
      sample_fall <= '0;
    end else if (capture) begin
      prev       <= sync_data;
      prev_valid <= 1'b1;
      if (prev_valid) begin
        sample_rise <= sync_data & ~prev;
        sample_fall <= ~sync_data & prev;
      end else begin
        sample_rise <= '0;
        sample_fall <= '0;
      end
    end else if (!enable) begin
      prev_valid <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_input_sampler.sv
// tb/tb_input_sampler.sv - directed self-checking bench for input_sampler
module tb_input_sampler;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [31:0] sync_data;
  logic [23:0] divider;
  logic        enable;
  logic        clear_overrun;
  logic        sample_ready;
  logic        sample_valid;
  logic [31:0] sample_data;
  logic        overrun;
`ifdef INPUT_SAMPLER_EDGE_EN
  logic [31:0] sample_rise;
  logic [31:0] sample_fall;
`endif

  int checks = 0;
  int errors = 0;

  input_sampler dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .sync_data     (sync_data),
    .divider       (divider),
    .enable        (enable),
    .clear_overrun (clear_overrun),
    .sample_ready  (sample_ready),
    .sample_valid  (sample_valid),
    .sample_data   (sample_data),
    .overrun       (overrun)
`ifdef INPUT_SAMPLER_EDGE_EN
    ,
    .sample_rise   (sample_rise),
    .sample_fall   (sample_fall)
`endif
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    reset_n       = 1'b0;
    enable        = 1'b0;
    divider       = 24'd3;
    sample_ready  = 1'b1;
    sync_data     = 32'h0;
    clear_overrun = 1'b0;
    step();
    step();
    chk("reset_valid", 32'(sample_valid), 32'd0);
    chk("reset_data", sample_data, 32'h0);
    chk("reset_overrun", 32'(overrun), 32'd0);

    // divider=3, ready high: one sample every 4 clocks
    reset_n = 1'b1;
    enable  = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      sync_data = 32'hA000_0000 + 32'(k);
      step();
      chk("div3_valid", 32'(sample_valid), 32'((k % 4) == 0));
      if ((k % 4) == 0) chk("div3_data", sample_data, 32'hA000_0000 + 32'(k));
    end
    chk("div3_overrun", 32'(overrun), 32'd0);

    // divider=0, ready high: continuous back-to-back valid
    enable  = 1'b0;
    divider = 24'd0;
    step();
    chk("idle_valid", 32'(sample_valid), 32'd0);
    enable = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      sync_data = 32'hB000_0000 + 32'(k);
      step();
      chk("div0_valid", 32'(sample_valid), 32'd1);
      chk("div0_data", sample_data, 32'hB000_0000 + 32'(k));
    end
    chk("div0_overrun", 32'(overrun), 32'd0);

    // ready low after first capture: held sample, overrun from the second sample point
    enable = 1'b0;
    step();
    enable       = 1'b1;
    sample_ready = 1'b0;
    sync_data    = 32'hC000_0001;
    step();
    chk("hold_first_valid", 32'(sample_valid), 32'd1);
    chk("hold_first_data", sample_data, 32'hC000_0001);
    chk("hold_first_overrun", 32'(overrun), 32'd0);
    for (int k = 2; k <= 4; k++) begin
      sync_data = 32'hC000_0000 + 32'(k);
      step();
      chk("hold_valid", 32'(sample_valid), 32'd1);
      chk("hold_data", sample_data, 32'hC000_0001);
      chk("hold_overrun", 32'(overrun), 32'd1);
    end

    // clear coinciding with a drop loses to the drop
    clear_overrun = 1'b1;
    sync_data     = 32'hC000_0005;
    step();
    chk("clr_drop_overrun", 32'(overrun), 32'd1);
    chk("clr_drop_data", sample_data, 32'hC000_0001);

    // quiet-cycle clear; disabling does not cancel the pending sample
    enable = 1'b0;
    step();
    clear_overrun = 1'b0;
    chk("clr_quiet_overrun", 32'(overrun), 32'd0);
    chk("disable_keeps_valid", 32'(sample_valid), 32'd1);
    chk("disable_keeps_data", sample_data, 32'hC000_0001);

    // reset with a pending sample, then first capture divider+1 clocks after enable
    divider = 24'd2;
    reset_n = 1'b0;
    step();
    chk("rst_pending_valid", 32'(sample_valid), 32'd0);
    chk("rst_pending_overrun", 32'(overrun), 32'd0);
    reset_n      = 1'b1;
    enable       = 1'b1;
    sample_ready = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      sync_data = 32'hD000_0000 + 32'(k);
      step();
      chk("post_rst_valid", 32'(sample_valid), 32'(k == 3));
    end
    chk("post_rst_data", sample_data, 32'hD000_0003);

`ifdef INPUT_SAMPLER_EDGE_EN
    enable  = 1'b0;
    divider = 24'd0;
    reset_n = 1'b0;
    step();
    chk("edge_rst_rise", sample_rise, 32'h0);
    chk("edge_rst_fall", sample_fall, 32'h0);
    reset_n   = 1'b1;
    enable    = 1'b1;
    sync_data = 32'h0;
    step();
    chk("edge0_rise", sample_rise, 32'h0);
    chk("edge0_fall", sample_fall, 32'h0);
    sync_data = 32'h5;
    step();
    chk("edge1_rise", sample_rise, 32'h5);
    chk("edge1_fall", sample_fall, 32'h0);
    sync_data = 32'h3;
    step();
    chk("edge2_rise", sample_rise, 32'h2);
    chk("edge2_fall", sample_fall, 32'h4);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/input_sampler.md
INPUT_SAMPLER -- requirements
Module: input_sampler

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, meaning the number of sampled channels.
REQ-002 The block SHALL have parameter DIVW, default 24, meaning the width of the sample-rate divider.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 The block SHALL have port reset_n, input, 1 bit: synchronous, active-low reset.
REQ-005 The block SHALL have port sync_data, input, WIDTH bits: channel data already passed through the two-flop synchronizer.
REQ-006 The block SHALL have port divider, input, DIVW bits: the sample period is divider+1 clocks.
REQ-007 The block SHALL have port enable, input, 1 bit: sampling is active while high.
REQ-008 The block SHALL have port clear_overrun, input, 1 bit: a one-cycle pulse that clears the overrun flag.
REQ-009 The block SHALL have port sample_ready, input, 1 bit: the downstream stage accepts the sample.
REQ-010 The block SHALL have port sample_valid, output, 1 bit: sample_data holds an unaccepted sample.
REQ-011 The block SHALL have port sample_data, output, WIDTH bits: the captured sample.
REQ-012 The block SHALL have port overrun, output, 1 bit: sticky flag indicating that a sample was dropped.
REQ-013 The block SHALL have ports sample_rise and sample_fall, outputs, WIDTH bits each, present only under INPUT_SAMPLER_EDGE_EN: per-channel edge flags.

Function
REQ-014 The divider counter SHALL load divider when enable is low and SHALL decrement each clock when enable is high; a sample point occurs when enable is high and the count is 0, and the counter then reloads divider.
REQ-015 divider=0 SHALL make every enabled clock a sample point; divider=N SHALL give exactly one sample point every N+1 enabled clocks.
REQ-016 A change to divider SHALL take effect only at the next reload; the count in progress completes.
REQ-017 At a sample point with the output slot free, sync_data of that cycle SHALL appear on sample_data with sample_valid high on the following cycle (1-clock latency).
REQ-018 The slot is free when sample_valid is low, or when sample_valid and sample_ready are both high in the same cycle; acceptance and a new capture in one cycle SHALL produce back-to-back valid with no overrun.
REQ-019 sample_valid and sample_data SHALL hold stable until accepted; sample_valid falls the cycle after acceptance unless a new sample is captured.
REQ-020 A sample point with the slot not free SHALL drop the new sample, leave the held sample unchanged, and set overrun.
REQ-021 overrun SHALL stay set until clear_overrun or reset; if clear_overrun and a new overrun occur in the same cycle, overrun SHALL remain set.
REQ-022 Deasserting enable SHALL NOT cancel a pending sample_valid; the pending sample remains until accepted.

Reset
REQ-023 While reset_n is low at a clock edge, the counter SHALL load divider, and sample_valid, sample_data, overrun, sample_rise, sample_fall and the edge history SHALL all become 0.
REQ-024 Reset asserted mid-operation SHALL discard any pending sample without setting overrun.

Configuration
REQ-025 With INPUT_SAMPLER_EDGE_EN defined, the block SHALL keep the previously captured sample; on each capture it SHALL drive sample_rise = new & ~prev and sample_fall = ~new & prev, aligned with sample_data.
REQ-026 With INPUT_SAMPLER_EDGE_EN defined, the first capture after reset, or after enable has been low, SHALL report all-zero edge flags.
REQ-027 Without INPUT_SAMPLER_EDGE_EN, the edge ports, the history register and the edge logic SHALL be absent, and all other behaviour SHALL be identical.

Structure
REQ-028 The default WIDTH and DIVW constants SHALL live in shared package sampler_pkg.
REQ-029 The divider counter SHALL be a sub-module named sample_divider with ports clk, reset_n, enable, divider and tick.

Verification
REQ-030 divider=3, enable high, sample_ready always high -> sample_valid pulses every 4 clocks; sample_data equals sync_data from 1 clock earlier; overrun stays 0.
REQ-031 divider=0, sample_ready held low for 3 clocks after the first capture -> the first sample is held stable, overrun=1 from the second sample point, and the held data is unchanged.
REQ-032 divider=0, sample_ready high -> sample_valid stays high continuously and sample_data follows sync_data delayed by 1 clock.
REQ-033 Pending valid, then reset_n low for 1 clock -> sample_valid=0 and overrun=0; the next capture occurs divider+1 clocks after enable.
REQ-034 INPUT_SAMPLER_EDGE_EN defined, captures 0x0, 0x5, 0x3 -> sample_rise is 0x0, 0x5, 0x2 and sample_fall is 0x0, 0x0, 0x4.
REQ-035 Pulse clear_overrun in the same cycle as a new drop -> overrun remains 1; a pulse in a quiet cycle -> overrun becomes 0.
